// File: rtl/embed_pkg.sv
// Shared types and defaults for the ECG patch-embedding frame sequencer.
package embed_pkg;
    localparam int N_SAMP_DEF = 15;
    localparam int Q_FRAC     = 4;
    localparam int DW_DEF     = 2 * Q_FRAC;

    typedef logic signed [DW_DEF-1:0] q44_t;

    typedef enum logic [1:0] {FILL, START, WAIT, HOLD} emb_state_t;
endpackage

// File: rtl/embed_frame_ctrl_if.sv
// Sample stream, engine handshake and downstream handshake of the frame sequencer.
// slave = the sequencer itself, master = the surrounding producer/engine/consumer.
interface embed_frame_ctrl_if #(
    parameter int N_SAMP = embed_pkg::N_SAMP_DEF,
    parameter int DW     = embed_pkg::DW_DEF
);
    logic                      s_valid;
    logic                      s_ready;
    logic [DW-1:0]             s_data;
    logic                      s_last;
    logic [N_SAMP-1:0][DW-1:0] ecg_buf;
    logic                      emb_start;
    logic                      emb_done;
    logic                      m_valid;
    logic                      m_ready;

    modport slave (
        input  s_valid, s_data, s_last, emb_done, m_ready,
        output s_ready, ecg_buf, emb_start, m_valid
    );

    modport master (
        output s_valid, s_data, s_last, emb_done, m_ready,
        input  s_ready, ecg_buf, emb_start, m_valid
    );
endinterface

// File: rtl/ecg_sample_buf.sv
// N_SAMP x DW sample register file: one indexed write port, full parallel read-out.
module ecg_sample_buf #(
    parameter int N_SAMP = 15,
    parameter int DW     = 8,
    parameter int PTR_W  = $clog2(N_SAMP)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [PTR_W-1:0]          wr_ptr,
    input  logic [DW-1:0]             wr_data,
    output logic [N_SAMP-1:0][DW-1:0] rd_data
);
    logic [N_SAMP-1:0][DW-1:0] mem_q, mem_d;

    // NOTE: mem_d takes mem_q as its default first so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr] = wr_data;
    end

    // NOTE: the storage is reset because the engine reads every entry directly, and an
    // all-zero frame is the defined content after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;  // NOTE: non-blocking, so every flop samples pre-edge values.
    end

    assign rd_data = mem_q;
endmodule

// File: rtl/embed_frame_ctrl.sv
// Frame sequencer: fills one ECG frame, launches the embedding engine, then offers the
// held frame downstream, flagging malformed frames and engine timeouts.
module embed_frame_ctrl
    import embed_pkg::*;
#(
    parameter int N_SAMP = N_SAMP_DEF,
    parameter int DW     = DW_DEF,
    parameter int TO_CYC = 1024,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    embed_frame_ctrl_if.slave bus,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              err_len,
    output logic              err_to
);
    localparam int               PTR_W    = $clog2(N_SAMP);
    localparam int               TMR_W    = $clog2(TO_CYC);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_SAMP - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TO_CYC - 1);

    emb_state_t       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             drop_q, drop_d;
    logic             err_len_q, err_len_d;
    logic             err_to_q, err_to_d;
    logic             emb_start_q, emb_start_d;
    logic             wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            timer_q     <= '0;
            frame_cnt_q <= '0;
            drop_q      <= 1'b0;
            err_len_q   <= 1'b0;
            err_to_q    <= 1'b0;
            emb_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            timer_q     <= timer_d;
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
            err_len_q   <= err_len_d;
            err_to_q    <= err_to_d;
            emb_start_q <= emb_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        timer_d     = timer_q;
        frame_cnt_d = frame_cnt_q;
        drop_d      = drop_q;
        err_len_d   = err_len_q;
        err_to_d    = err_to_q;
        wr_en       = 1'b0;
        // The pulse is re-registered, landing on the first WAIT cycle.
        emb_start_d = (state_q == START);

        case (state_q)
            FILL: begin
                if (bus.s_valid) begin
                    // While draining an over-long frame, swallow samples up to its s_last.
                    if (drop_q) begin
                        if (bus.s_last) drop_d = 1'b0;
                    end else begin
                        wr_en = 1'b1;
                        if (wr_ptr_q == LAST_IDX) begin
                            wr_ptr_d = '0;
                            if (bus.s_last) begin
                                state_d = START;
                            end else begin
                                err_len_d = 1'b1;
                                drop_d    = 1'b1;
                            end
                        end else if (bus.s_last) begin
                            err_len_d = 1'b1;
                            wr_ptr_d  = '0;
                        end else begin
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        end
                    end
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.emb_done) begin
                    state_d = HOLD;
                end else if (timer_q == TMR_MAX) begin
                    err_to_d = 1'b1;
                    state_d  = FILL;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    ecg_sample_buf #(
        .N_SAMP (N_SAMP),
        .DW     (DW),
        .PTR_W  (PTR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_ptr  (wr_ptr_q),
        .wr_data (bus.s_data),
        .rd_data (bus.ecg_buf)
    );

    assign bus.s_ready   = (state_q == FILL);
    assign bus.m_valid   = (state_q == HOLD);
    assign bus.emb_start = emb_start_q;
    assign busy          = !((state_q == FILL) && (wr_ptr_q == '0));
    assign frame_cnt     = frame_cnt_q;
    assign err_len       = err_len_q;
    assign err_to        = err_to_q;
endmodule

// File: tb/tb_embed_frame_ctrl.sv
// Scoreboard bench for embed_frame_ctrl: good frames are queued when sent and
// compared against ecg_buf when the sequencer offers them downstream.
module tb_embed_frame_ctrl;
    import embed_pkg::*;

    localparam int N  = N_SAMP_DEF;
    localparam int DW = DW_DEF;
    localparam int TO = 16;
    localparam int CW = 16;

    typedef logic [N-1:0][DW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic          err_len;
    logic          err_to;
    logic [CW-1:0] frame_cnt;

    int     vectors     = 0;
    int     miscompares = 0;
    int     exp_cnt     = 0;
    frame_t sb_q[$];

    embed_frame_ctrl_if #(.N_SAMP(N), .DW(DW)) bus ();

    embed_frame_ctrl #(
        .N_SAMP (N),
        .DW     (DW),
        .TO_CYC (TO),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err_len   (err_len),
        .err_to    (err_to)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_s_ready"},   128'(bus.s_ready),   128'(1));
        check({p, "_emb_start"}, 128'(bus.emb_start), 128'(0));
        check({p, "_m_valid"},   128'(bus.m_valid),   128'(0));
        check({p, "_busy"},      128'(busy),          128'(0));
        check({p, "_frame_cnt"}, 128'(frame_cnt),     128'(0));
        check({p, "_err_len"},   128'(err_len),       128'(0));
        check({p, "_err_to"},    128'(err_to),        128'(0));
        check({p, "_ecg_buf"},   128'(bus.ecg_buf),   128'(0));
    endtask

    // Drive one sample at a falling edge; returns on the falling edge after it is taken.
    task automatic send_sample(input q44_t d, input logic last);
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (bus.s_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (bus.s_ready !== 1'b1) check("s_ready_wait", 128'(bus.s_ready), 128'(1));
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input logic [7:0] base,
                              input bit rnd, output frame_t f);
        q44_t d;
        f = '0;
        for (int i = 0; i < n; i++) begin
            d = rnd ? q44_t'($urandom_range(0, 255)) : q44_t'(base + 8'(i));
            if (i < N) f[i] = d;
            send_sample(d, i == last_at - 1);
        end
    endtask

    task automatic wait_start();
        int g = 0;
        while (bus.emb_start !== 1'b1 && g < 8) begin
            @(negedge clk);
            g++;
        end
        check("emb_start_seen", 128'(bus.emb_start), 128'(1));
    endtask

    // Called on the falling edge where emb_start is seen; pulses emb_done dly cycles later.
    task automatic engine_done(input int dly);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("emb_start_width", 128'(bus.emb_start), 128'(0));
                check("s_ready_in_wait", 128'(bus.s_ready), 128'(0));
            end
        end
        bus.emb_done = 1'b1;
        @(negedge clk);
        bus.emb_done = 1'b0;
    endtask

    task automatic drain(input int hold);
        frame_t exp_f = '0;
        int     g     = 0;
        while (bus.m_valid !== 1'b1 && g < 32) begin
            @(negedge clk);
            g++;
        end
        check("m_valid_up", 128'(bus.m_valid), 128'(1));
        if (sb_q.size() == 0) check("sb_underflow", 128'(sb_q.size()), 128'(1));
        else exp_f = sb_q.pop_front();
        check("ecg_buf_out", 128'(bus.ecg_buf), 128'(exp_f));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("m_valid_hold", 128'(bus.m_valid), 128'(1));
            check("ecg_buf_hold", 128'(bus.ecg_buf), 128'(exp_f));
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        exp_cnt++;
        check("m_valid_drop", 128'(bus.m_valid), 128'(0));
        check("s_ready_back", 128'(bus.s_ready), 128'(1));
        check("frame_cnt", 128'(frame_cnt), 128'(16'(exp_cnt)));
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen |= bus.emb_start;
        end
        check(tag, 128'(seen), 128'(0));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        frame_t f;
        rst          = 1'b1;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_last   = 1'b0;
        bus.emb_done = 1'b0;
        bus.m_ready  = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Good frame 0x01..0x0F: two-cycle start latency, then a held handoff.
        send_frame(15, 15, 8'h01, 1'b0, f);
        sb_q.push_back(f);
        check("t1_ecg_buf", 128'(bus.ecg_buf), 128'(f));
        check("t1_s_ready", 128'(bus.s_ready), 128'(0));
        check("t1_busy", 128'(busy), 128'(1));
        check("t1_start_early", 128'(bus.emb_start), 128'(0));
        @(negedge clk);
        check("t1_start", 128'(bus.emb_start), 128'(1));
        engine_done(10);
        drain(5);

        // Short frame is dropped; the following frame still goes through.
        send_frame(8, 8, 8'h11, 1'b0, f);
        check("t3_err_len", 128'(err_len), 128'(1));
        check("t3_busy", 128'(busy), 128'(0));
        expect_idle("t3_no_start", 6);
        send_frame(15, 15, 8'h00, 1'b1, f);
        sb_q.push_back(f);
        wait_start();
        engine_done(4);
        drain(1);

        // Long frame: tail discarded, next frame must land at index 0.
        pulse_reset();
        check("t4_err_len_clr", 128'(err_len), 128'(0));
        send_frame(18, 18, 8'h21, 1'b0, f);
        check("t4_err_len", 128'(err_len), 128'(1));
        check("t4_busy", 128'(busy), 128'(0));
        expect_idle("t4_no_start", 6);
        send_frame(15, 15, 8'h41, 1'b0, f);
        sb_q.push_back(f);
        wait_start();
        engine_done(3);
        drain(2);

        // emb_done on the last allowed wait cycle wins over the timeout.
        send_frame(15, 15, 8'h00, 1'b1, f);
        sb_q.push_back(f);
        wait_start();
        engine_done(15);
        check("t5_done_last_hold", 128'(bus.m_valid), 128'(1));
        check("t5_done_last_err_to", 128'(err_to), 128'(0));
        drain(0);

        // No emb_done: timeout 16 cycles after emb_start, frame dropped.
        send_frame(15, 15, 8'h00, 1'b1, f);
        wait_start();
        repeat (15) @(negedge clk);
        check("t5_to_pending", 128'(err_to), 128'(0));
        check("t5_to_waiting", 128'(bus.s_ready), 128'(0));
        @(negedge clk);
        check("t5_err_to", 128'(err_to), 128'(1));
        check("t5_to_fill", 128'(bus.s_ready), 128'(1));
        check("t5_to_no_valid", 128'(bus.m_valid), 128'(0));
        bus.emb_done = 1'b1;
        @(negedge clk);
        bus.emb_done = 1'b0;
        @(negedge clk);
        check("t5_stray_done", 128'(bus.m_valid), 128'(0));

        // Asynchronous reset in WAIT, then in HOLD with m_valid high.
        send_frame(15, 15, 8'h00, 1'b1, f);
        wait_start();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals("t6_wait");
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 0;
        send_frame(15, 15, 8'h00, 1'b1, f);
        sb_q.push_back(f);
        wait_start();
        engine_done(2);
        drain(0);
        send_frame(15, 15, 8'h00, 1'b1, f);
        wait_start();
        engine_done(2);
        check("t6_hold_valid", 128'(bus.m_valid), 128'(1));
        check("t6_hold_cnt", 128'(frame_cnt), 128'(1));
        #2 rst = 1'b1;
        #1 check_reset_vals("t6_hold");
        @(negedge clk);
        rst = 1'b0;

        check("sb_empty", 128'(sb_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary expected summary before 100000");
        $fatal(1, "watchdog expired");
    end
endmodule
